// File: rtl/pipeline_stage_skid_if.sv
// Valid/ready/data handshake bundle for one side of an elastic pipeline stage.
// The master drives valid and data; the slave drives ready.
interface pipeline_stage_skid_if #(
  parameter int DATA_W = 160
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline register between CPU stages. A main register plus a skid
// register let upstream and downstream handshakes be fully registered: in_ready
// and out_valid are decoded from state only. Flush kills all held beats and the
// beat presented that cycle. Saturating stall and bubble counters are included.
module pipeline_stage_skid #(
  parameter int                DATA_W        = 160,
  parameter logic [DATA_W-1:0] RESET_PAYLOAD = '0,
  parameter int                CNT_W         = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  pipeline_stage_skid_if.slave      up,
  pipeline_stage_skid_if.master     dn,
  output logic [1:0]                occupancy,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  // Encoding equals the number of held entries so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_p0;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_data_p0;
  logic [DATA_W-1:0] main_data_nxt;
  logic [DATA_W-1:0] skid_data_p0;
  logic [DATA_W-1:0] skid_data_nxt;
  logic              main_vld_p0;
  logic              skid_vld_p0;
  logic              in_fire;
  logic              out_fire;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] one;
    one = {{(CNT_W-1){1'b0}}, 1'b1};
    return (&c) ? c : c + one;
  endfunction

  assign main_vld_p0 = (state_p0 != EMPTY);
  assign skid_vld_p0 = (state_p0 == TWO);

  assign up.ready  = ~skid_vld_p0;
  assign dn.valid  = main_vld_p0;
  assign dn.data   = main_data_p0;
  assign occupancy = state_p0;

  assign in_fire  = up.valid & up.ready;
  assign out_fire = main_vld_p0 & dn.ready;

  // Next-state and payload steering; flush overrides every handshake outcome.
  always_comb begin
    state_nxt     = state_p0;
    main_data_nxt = main_data_p0;
    skid_data_nxt = skid_data_p0;
    if (flush) begin
      state_nxt     = EMPTY;
      main_data_nxt = RESET_PAYLOAD;
      skid_data_nxt = RESET_PAYLOAD;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_nxt     = ONE;
            main_data_nxt = up.data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_nxt = up.data;
          end else if (in_fire) begin
            state_nxt     = TWO;
            skid_data_nxt = up.data;
          end else if (out_fire) begin
            state_nxt     = EMPTY;
            main_data_nxt = RESET_PAYLOAD;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt     = ONE;
            main_data_nxt = skid_data_p0;
            skid_data_nxt = RESET_PAYLOAD;
          end
        end
        default: begin
          state_nxt     = EMPTY;
          main_data_nxt = RESET_PAYLOAD;
          skid_data_nxt = RESET_PAYLOAD;
        end
      endcase
    end
  end

  // State and payload registers; reset empties the buffer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0     <= EMPTY;
      main_data_p0 <= RESET_PAYLOAD;
      skid_data_p0 <= RESET_PAYLOAD;
    end else begin
      state_p0     <= state_nxt;
      main_data_p0 <= main_data_nxt;
      skid_data_p0 <= skid_data_nxt;
    end
  end

  // Performance counters sample the outputs as seen before the edge; flush does not touch them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_vld_p0 && !dn.ready) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (!main_vld_p0 && dn.ready) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

endmodule

// File: doc/pipeline_stage_skid.md
Name: pipeline_stage_skid

Overview:
Parametrised elastic pipeline register that replaces the fixed stall/flush latch between adjacent CPU stages (IF->ID, ID->EX, ...).
- Carries an opaque DATA_W-bit payload (PC, instruction, decoded control bundle) with a valid/ready handshake instead of a global stall.
- Includes a 2-entry skid buffer, so neither direction has a combinational ready/valid path.
- Supports synchronous flush that inserts a zeroed bubble.
- Provides saturating stall/bubble performance counters.

Parameters:
DATA_W, 160, payload width in bits (e.g. 64 PC + 32 inst + 64 control).
RESET_PAYLOAD, {DATA_W{1'b0}}, value loaded into payload registers on reset, flush and when emptied (bubble = all-zero control, i.e. no write, no memory access).
CNT_W, 32, width of each performance counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all held entries and of the current input beat
in_valid  input  1  upstream beat valid
in_ready  output  1  buffer can accept a beat; registered
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream beat valid; registered
out_ready  input  1  downstream accepts beat
out_data  output  DATA_W  downstream payload; registered
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0; saturating
bubble_cnt  output  CNT_W  cycles with out_valid=0 and out_ready=1; saturating

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates occur on posedge clk except reset.
- Storage:
  - main register (drives out_data/out_valid).
  - skid register plus skid_valid.
- States: EMPTY (occ 0), ONE (occ 1, main valid), TWO (occ 2, main and skid valid).
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
  - Both are decoded from registered state only.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data; else stay.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire & ~out_fire -> TWO, skid<=in_data. ~in_fire & out_fire -> EMPTY, main<=RESET_PAYLOAD. Neither -> hold.
  - TWO: out_fire -> ONE, main<=skid, skid<=RESET_PAYLOAD. Else hold. in_valid is ignored because in_ready=0.
- Ordering: strict FIFO; skid contents always leave after main.
- Latency: in_fire in cycle N when EMPTY gives out_valid=1 with that payload in cycle N+1.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- out_data is stable while out_valid=1 and out_ready=0.
- flush=1 (highest priority below reset):
  - Next state is EMPTY; main and skid <= RESET_PAYLOAD.
  - A beat presented in the same cycle is dropped even if in_fire=1.
  - A beat consumed downstream by out_fire in the flush cycle counts as delivered.
  - Next cycle: out_valid=0, in_ready=1.
- reset=1, asynchronous, at any time including mid-transfer:
  - state EMPTY; main and skid = RESET_PAYLOAD.
  - out_valid=0, in_ready=1, occupancy=0.
  - stall_cnt=0, bubble_cnt=0.
  - Deassertion is synchronised externally.
- Counters:
  - Increment by 1 per qualifying cycle, sampled on the pre-edge outputs.
  - Saturate at 2^CNT_W-1.
  - Unaffected by flush.
- occupancy mirrors state (0/1/2), registered.

Test Plan:
- Reset mid-stream: reset=1 while in TWO -> immediately out_valid=0, in_ready=1, occupancy=0, out_data=0, counters 0.
- Streaming: out_ready=1, in_valid=1 for 4 cycles with payloads 0x11,0x22,0x33,0x44 -> out_data 0x11..0x44 on consecutive cycles starting one cycle after the first, occupancy stays 1, stall_cnt=0.
- Backpressure/skid: send 0xA1,0xA2 with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA1 held, stall_cnt increments each cycle. Raise out_ready -> 0xA1 then 0xA2 in order, in_ready returns 1 after the first out_fire.
- Flush with full buffer plus input beat 0xB3: flush=1 -> next cycle out_valid=0, occupancy=0, out_data=0, and 0xB3 never appears at the output.
- Bubble counting: in_valid=0, out_ready=1 for 5 cycles from EMPTY -> bubble_cnt=5.
- Saturation: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt=15 and holds.
